// File: rtl/imem_loader.sv
// Byte-stream boot loader: assembles little-endian words from a valid/ready link
// and writes them to the instruction memory, holding the CPU until the load is done.
module imem_loader #(
    parameter int ADDR_W    = 12,
    parameter int MEM_DEPTH = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [15:0]       len;
    logic [1:0]        idx;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       word;
    logic              restart;
    logic              xfer;
    logic [15:0]       len_hdr;
    logic              last_word;

    assign xfer      = byte_valid & byte_ready;
    // Full count as it stands while the high header byte is on the bus.
    assign len_hdr   = {byte_data, len[7:0]};
    assign last_word = (16'(words_loaded) + 16'd1) == len;

    assign imem_waddr = addr;
    assign imem_wdata = word;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nx   = state;
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        cpu_hold   = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        restart    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    restart  = 1'b1;
                    state_nx = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (byte_valid) state_nx = S_LEN_HI;
            end
            S_LEN_HI: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (byte_valid) begin
                    if (len_hdr == 16'd0)                   state_nx = S_DONE;
                    else if (len_hdr > 16'(MEM_DEPTH))      state_nx = S_ERROR;
                    else                                    state_nx = S_DATA;
                end
            end
            S_DATA: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (byte_valid && idx == 2'd3) state_nx = S_WRITE;
            end
            S_WRITE: begin
                imem_we  = 1'b1;
                cpu_hold = 1'b1;
                state_nx = last_word ? S_DONE : S_DATA;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    restart  = 1'b1;
                    state_nx = S_LEN_LO;
                end
            end
            S_ERROR: begin
                err = 1'b1;
                if (start) begin
                    restart  = 1'b1;
                    state_nx = S_LEN_LO;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len          <= '0;
            idx          <= '0;
            addr         <= '0;
            word         <= '0;
            words_loaded <= '0;
        end else begin
            if (restart) begin
                words_loaded <= '0;
                addr         <= '0;
                idx          <= '0;
            end
            case (state)
                S_LEN_LO: if (xfer) len[7:0]  <= byte_data;
                S_LEN_HI: if (xfer) len[15:8] <= byte_data;
                S_DATA: begin
                    if (xfer) begin
                        word[{idx, 3'b000} +: 8] <= byte_data;
                        idx                      <= idx + 2'd1;
                    end
                end
                S_WRITE: begin
                    // A full-depth load leaves addr at MEM_DEPTH only after the last write.
                    addr         <= addr + 1'b1;
                    words_loaded <= words_loaded + 1'b1;
                    idx          <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table-driven header/length cases plus
// hand-written sequences for latency, backpressure, full depth and reset.
module tb_imem_loader;

    localparam int ADDR_W    = 12;
    localparam int MEM_DEPTH = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    wr_t wq[$];

    always @(negedge clk) begin
        if (!rst && imem_we) wq.push_back({imem_waddr, imem_wdata});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge right after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        for (int i = 0; i < gap; i++) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) begin
            fail_now("send_byte");
            byte_valid = 1'b0;
            return;
        end
        @(negedge clk);
    endtask

    task automatic send_hdr(input logic [15:0] n);
        send_byte(n[7:0], 0);
        send_byte(n[15:8], 0);
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] sh;
            sh = w >> (8 * i);
            send_byte(sh[7:0], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
    endtask

    task automatic wait_end(input string name);
        int n;
        n = 0;
        byte_valid = 1'b0;
        while (!(done || err) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!(done || err)) fail_now(name);
    endtask

    typedef struct {
        logic [15:0] n;
        logic        exp_done;
        logic        exp_err;
        int          exp_words;
        int          gap;
    } vec_t;

    vec_t tbl[5];

    logic [7:0] t1_bytes[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{16'd0,     1'b1, 1'b0, 0, 0};
        tbl[1] = '{16'd1025,  1'b0, 1'b1, 0, 0};
        tbl[2] = '{16'd1,     1'b1, 1'b0, 1, 0};
        tbl[3] = '{16'hFFFF,  1'b0, 1'b1, 0, 0};
        tbl[4] = '{16'd3,     1'b1, 1'b0, 3, 2};

        t1_bytes = '{8'h02, 8'h00, 8'h93, 8'h04, 8'h00, 8'h06, 8'h13, 8'h05, 8'h00, 8'h02};

        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs",
              {byte_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, done, err, words_loaded}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven header and length cases; data = address ^ A5A5A5A5.
        foreach (tbl[i]) begin
            wq.delete();
            pulse_start();
            check($sformatf("v%0d_len_lo_ready", i), {cpu_hold, byte_ready, done, err}, 4'b1100);
            send_hdr(tbl[i].n);
            if (!tbl[i].exp_err) begin
                for (int w = 0; w < tbl[i].exp_words; w++)
                    send_word(32'(w) ^ 32'hA5A5A5A5, tbl[i].gap);
            end
            wait_end($sformatf("v%0d_end", i));
            @(negedge clk);
            check($sformatf("v%0d_done_err", i), {done, err}, {tbl[i].exp_done, tbl[i].exp_err});
            check($sformatf("v%0d_words", i), words_loaded, tbl[i].exp_words);
            check($sformatf("v%0d_hold_ready", i), {cpu_hold, byte_ready}, 2'b00);
            check($sformatf("v%0d_nwrites", i), wq.size(), tbl[i].exp_words);
            for (int w = 0; w < tbl[i].exp_words && w < wq.size(); w++) begin
                check($sformatf("v%0d_addr%0d", i, w), wq[w].a, w);
                check($sformatf("v%0d_data%0d", i, w), wq[w].d, 32'(w) ^ 32'hA5A5A5A5);
            end
        end

        // Basic load with continuous valid; write appears one cycle after the 4th byte.
        wq.delete();
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            send_byte(t1_bytes[i], 0);
            if (i == 5) begin
                check("t1_we_latency", imem_we, 1'b1);
                check("t1_w0", {imem_waddr, imem_wdata}, {12'd0, 32'h06000493});
                check("t1_ready_in_write", byte_ready, 1'b0);
            end
        end
        wait_end("t1_end");
        @(negedge clk);
        check("t1_nwrites", wq.size(), 2);
        if (wq.size() == 2) begin
            check("t1_q0", wq[0], {12'd0, 32'h06000493});
            check("t1_q1", wq[1], {12'd1, 32'h02000513});
        end
        check("t1_final", {done, cpu_hold, words_loaded}, {1'b1, 1'b0, 13'd2});

        // Same stream with random gaps; first byte of word 1 is held through WRITE.
        wq.delete();
        pulse_start();
        for (int i = 0; i < 10; i++)
            send_byte(t1_bytes[i], (i == 6) ? 0 : int'($urandom_range(0, 3)));
        wait_end("t4_end");
        @(negedge clk);
        check("t4_nwrites", wq.size(), 2);
        if (wq.size() == 2) begin
            check("t4_q0", wq[0], {12'd0, 32'h06000493});
            check("t4_q1", wq[1], {12'd1, 32'h02000513});
        end
        check("t4_final", {done, err, words_loaded}, {1'b1, 1'b0, 13'd2});

        // Full depth load.
        begin
            int errs;
            errs = 0;
            wq.delete();
            pulse_start();
            send_hdr(16'd1024);
            for (int w = 0; w < MEM_DEPTH; w++)
                send_word(32'(w) ^ 32'hA5A5A5A5, 0);
            wait_end("t5_end");
            @(negedge clk);
            check("t5_nwrites", wq.size(), MEM_DEPTH);
            foreach (wq[k]) begin
                if (wq[k] !== {12'(k), 32'(k) ^ 32'hA5A5A5A5}) errs++;
            end
            check("t5_data_errs", errs, 0);
            if (wq.size() > 0) check("t5_last_addr", wq[wq.size()-1].a, 12'd1023);
            check("t5_final", {done, err, words_loaded}, {1'b1, 1'b0, 13'd1024});
        end

        // Reset in the middle of a 3-word load.
        wq.delete();
        pulse_start();
        send_hdr(16'd3);
        send_word(32'h11223344, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        check("t6_one_write", wq.size(), 1);
        #3 rst = 1'b1;
        #1;
        check("t6_async_reset_outputs",
              {byte_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, done, err, words_loaded}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int ready_seen;
            ready_seen = 0;
            byte_valid = 1'b1;
            byte_data  = 8'h55;
            for (int c = 0; c < 6; c++) begin
                if (byte_ready) ready_seen++;
                @(negedge clk);
            end
            byte_valid = 1'b0;
            check("t6_no_ready_after_reset", ready_seen, 0);
        end
        check("t6_idle_outputs", {cpu_hold, done, err, words_loaded}, 16'd0);
        check("t6_no_new_writes", wq.size(), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
